// File: rtl/fc_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_seq
// Brief    : Fully-connected layer sequencer. Master of the shared single-port
//            weight/activation RAM: loads FRT_CELL activations, then for each
//            of BCK_CELL neurons streams FRT_CELL weights through a signed MAC
//            and writes the 16-bit saturated result back into the RAM.
//            Optional macro FC_RELU_EN: clamp negative results to 0 on write.
// Revision : 1.0 - initial release
// ============================================================================
module fc_layer_seq #(
   parameter int FRT_CELL = 10,
   parameter int BCK_CELL = 5,
   parameter int IN_BASE  = 0,
   parameter int W_BASE   = FRT_CELL,
   parameter int OUT_BASE = FRT_CELL * BCK_CELL + FRT_CELL,
   parameter int ACC_W    = 40
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   // Phase counter covers FRT_CELL issue cycles plus one drain cycle.
   localparam int CW = $clog2(FRT_CELL + 1);
   localparam int JW = (BCK_CELL > 1) ? $clog2(BCK_CELL) : 1;

   localparam logic [CW-1:0] C_CNT_LAST      = CW'(FRT_CELL);
   localparam logic [CW-1:0] C_CNT_ADDR_LAST = CW'(FRT_CELL - 1);
   localparam logic [JW-1:0] C_J_LAST        = JW'(BCK_CELL - 1);

   localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32768);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MAC   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                   state_q;
   logic [CW-1:0]            cnt_q;
   logic [JW-1:0]            j_q;
   logic [15:0]              wptr_q;
   logic [15:0]              optr_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [15:0]              x_q [FRT_CELL];
   logic                     busy_q;
   logic                     done_q;
   logic [15:0]              mem_addr_q;
   logic                     mem_we_q;
   logic [15:0]              mem_wdata_q;

   logic signed [31:0]       prod_d;
   logic signed [ACC_W-1:0]  acc_d;
   logic [15:0]              sat_d;
   logic [15:0]              wdata_d;

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

   // MAC datapath: x_q[0] is always the activation paired with the weight on mem_rdata.
   always_comb begin
      prod_d = $signed(mem_rdata) * $signed(x_q[0]);
      acc_d  = acc_q + {{(ACC_W - 32){prod_d[31]}}, prod_d};
      if (acc_d > C_SAT_MAX) begin
         sat_d = 16'h7FFF;
      end else if (acc_d < C_SAT_MIN) begin
         sat_d = 16'h8000;
      end else begin
         sat_d = acc_d[15:0];
      end
`ifdef FC_RELU_EN
      wdata_d = sat_d[15] ? 16'h0000 : sat_d;
`else
      wdata_d = sat_d;
`endif
   end

   // Sequencer FSM with registered RAM-port outputs; activations live in a
   // shift ring so the MAC never needs an indexed read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         j_q         <= '0;
         wptr_q      <= '0;
         optr_q      <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         for (int k = 0; k < FRT_CELL; k++) begin
            x_q[k] <= '0;
         end
      end else begin
         done_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  j_q        <= '0;
                  cnt_q      <= '0;
                  mem_addr_q <= 16'(IN_BASE);
                  wptr_q     <= 16'(W_BASE);
                  optr_q     <= 16'(OUT_BASE);
               end
            end
            S_LOAD: begin
               cnt_q <= cnt_q + 1'b1;
               // Data for the previous cycle's address arrives now; shift it in.
               if (cnt_q != '0) begin
                  for (int k = 0; k < FRT_CELL - 1; k++) begin
                     x_q[k] <= x_q[k + 1];
                  end
                  x_q[FRT_CELL - 1] <= mem_rdata;
               end
               if (cnt_q == C_CNT_LAST) begin
                  state_q    <= S_MAC;
                  cnt_q      <= '0;
                  acc_q      <= '0;
                  mem_addr_q <= wptr_q;
                  wptr_q     <= wptr_q + 16'd1;
               end else if (cnt_q < C_CNT_ADDR_LAST) begin
                  mem_addr_q <= mem_addr_q + 16'd1;
               end
            end
            S_MAC: begin
               cnt_q <= cnt_q + 1'b1;
               // Accumulate and rotate the ring so x_q[0] follows the weight index.
               if (cnt_q != '0) begin
                  acc_q <= acc_d;
                  for (int k = 0; k < FRT_CELL - 1; k++) begin
                     x_q[k] <= x_q[k + 1];
                  end
                  x_q[FRT_CELL - 1] <= x_q[0];
               end
               if (cnt_q == C_CNT_LAST) begin
                  state_q     <= S_WRITE;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= optr_q;
                  mem_wdata_q <= wdata_d;
               end else if (cnt_q < C_CNT_ADDR_LAST) begin
                  mem_addr_q <= wptr_q;
                  wptr_q     <= wptr_q + 16'd1;
               end
            end
            S_WRITE: begin
               optr_q <= optr_q + 16'd1;
               j_q    <= j_q + 1'b1;
               if (j_q == C_J_LAST) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  // Park on an input address so nothing written this run is read.
                  mem_addr_q <= 16'(IN_BASE);
               end else begin
                  state_q    <= S_MAC;
                  cnt_q      <= '0;
                  acc_q      <= '0;
                  mem_addr_q <= wptr_q;
                  wptr_q     <= wptr_q + 16'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_seq
// Brief    : Directed self-checking bench for fc_layer_seq (default geometry
//            plus a 1x1 instance), with behavioural 1-cycle-latency RAMs.
//            Expectations follow FC_RELU_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_layer_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   // default-geometry instance
   logic        start0 = 1'b0;
   logic        busy0, done0, mem_we0;
   logic [15:0] mem_addr0, mem_wdata0;
   logic [15:0] rdata0;
   logic [15:0] ram0 [0:127];
   logic        tbw0 = 1'b0;
   logic [6:0]  tbwa0 = '0;
   logic [15:0] tbwd0 = '0;
   int          wr_cnt = 0;
   int          bad_cnt = 0;
   int          done_cnt = 0;

   // 1x1 instance
   logic        start1 = 1'b0;
   logic        busy1, done1, mem_we1;
   logic [15:0] mem_addr1, mem_wdata1;
   logic [15:0] rdata1;
   logic [15:0] ram1 [0:15];
   logic        tbw1 = 1'b0;
   logic [3:0]  tbwa1 = '0;
   logic [15:0] tbwd1 = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   fc_layer_seq u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .done(done0),
      .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(rdata0)
   );

   fc_layer_seq #(.FRT_CELL(1), .BCK_CELL(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
      .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(rdata1)
   );

   // RAM models: registered read of last cycle's address, bench preload port has priority
   always @(posedge clk) begin
      if (tbw0) ram0[tbwa0] <= tbwd0;
      else if (mem_we0) ram0[mem_addr0[6:0]] <= mem_wdata0;
      rdata0 <= ram0[mem_addr0[6:0]];
   end

   always @(posedge clk) begin
      if (tbw1) ram1[tbwa1] <= tbwd1;
      else if (mem_we1) ram1[mem_addr1[3:0]] <= mem_wdata1;
      rdata1 <= ram1[mem_addr1[3:0]];
   end

   // write and done monitors for the default instance
   always @(posedge clk) begin
      if (mem_we0) begin
         wr_cnt <= wr_cnt + 1;
         if (mem_addr0 < 16'd60 || mem_addr0 > 16'd64) bad_cnt <= bad_cnt + 1;
      end
      if (done0) done_cnt <= done_cnt + 1;
   end

   function automatic logic signed [31:0] rx(input int v);
`ifdef FC_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ram0_fill(input int base, input int n, input int first, input int step);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         tbw0  = 1'b1;
         tbwa0 = 7'(base + k);
         tbwd0 = 16'(first + step * k);
      end
      @(negedge clk);
      tbw0 = 1'b0;
   endtask

   task automatic default_preload();
      ram0_fill(0, 10, 1, 1);
      ram0_fill(10, 50, -250, 3);
   endtask

   // pulse start0 (held for 'hold' cycles), return cycles from start to done, -1 on timeout
   task automatic run0(input int hold, input int budget, output int lat);
      int t0;
      lat = -1;
      @(negedge clk);
      start0 = 1'b1;
      t0 = cyc;
      for (int n = 1; n <= budget; n++) begin
         @(negedge clk);
         if (n >= hold) start0 = 1'b0;
         if (n == 1) check("busy_after_start", 32'(busy0), 1);
         if (done0) begin
            lat = cyc - t0;
            break;
         end
      end
      start0 = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int e4);
      check({tag, "_o0"}, 32'($signed(ram0[60])), rx(e0));
      check({tag, "_o1"}, 32'($signed(ram0[61])), rx(e1));
      check({tag, "_o2"}, 32'($signed(ram0[62])), rx(e2));
      check({tag, "_o3"}, 32'($signed(ram0[63])), rx(e3));
      check({tag, "_o4"}, 32'($signed(ram0[64])), rx(e4));
   endtask

   initial begin
      int lat;
      int w0, d0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_addr", 32'(mem_addr0), 0);
      check("rst_we", 32'(mem_we0), 0);
      check("rst_wdata", 32'(mem_wdata0), 0);
      reset_n = 1'b1;

      // ---- default dot products ----
      default_preload();
      w0 = wr_cnt; d0 = done_cnt;
      run0(1, 200, lat);
      check("basic_latency", lat, 72);
      @(negedge clk);
      check("basic_busy_idle", 32'(busy0), 0);
      check("basic_writes", wr_cnt - w0, 5);
      check("basic_bad_addr", bad_cnt, 0);
      check("basic_done_cnt", done_cnt - d0, 1);
      check_outputs("basic", -12760, -11110, -9460, -7810, -6160);

      // ---- positive saturation ----
      ram0_fill(0, 60, 32767, 0);
      run0(1, 200, lat);
      check("satp_latency", lat, 72);
      @(negedge clk);
      check_outputs("satp", 32767, 32767, 32767, 32767, 32767);

      // ---- negative saturation ----
      ram0_fill(10, 50, -32768, 0);
      run0(1, 200, lat);
      check("satn_latency", lat, 72);
      @(negedge clk);
      check_outputs("satn", -32768, -32768, -32768, -32768, -32768);

      // ---- start held high for 30 cycles ----
      default_preload();
      w0 = wr_cnt; d0 = done_cnt;
      run0(30, 200, lat);
      check("hold_latency", lat, 72);
      repeat (20) @(negedge clk);
      check("hold_writes", wr_cnt - w0, 5);
      check("hold_bad_addr", bad_cnt, 0);
      check("hold_done_cnt", done_cnt - d0, 1);
      check("hold_busy_idle", 32'(busy0), 0);
      check_outputs("hold", -12760, -11110, -9460, -7810, -6160);

      // ---- reset during MAC of neuron 2 ----
      ram0_fill(60, 5, 23130, 0);
      w0 = wr_cnt; d0 = done_cnt;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (39) @(negedge clk);
      check("abort_pre_writes", wr_cnt - w0, 2);
      check("abort_pre_busy", 32'(busy0), 1);
      reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy0), 0);
      check("abort_we", 32'(mem_we0), 0);
      check("abort_addr", 32'(mem_addr0), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      check("abort_writes", wr_cnt - w0, 2);
      check("abort_done_cnt", done_cnt - d0, 0);
      check("abort_o0", 32'($signed(ram0[60])), rx(-12760));
      check("abort_o1", 32'($signed(ram0[61])), rx(-11110));
      check("abort_o2", 32'($signed(ram0[62])), 23130);
      check("abort_o3", 32'($signed(ram0[63])), 23130);
      check("abort_o4", 32'($signed(ram0[64])), 23130);
      run0(1, 200, lat);
      check("rerun_latency", lat, 72);
      @(negedge clk);
      check_outputs("rerun", -12760, -11110, -9460, -7810, -6160);

      // ---- 1x1 geometry ----
      @(negedge clk);
      tbw1 = 1'b1; tbwa1 = 4'd0; tbwd1 = 16'(-3);
      @(negedge clk);
      tbwa1 = 4'd1; tbwd1 = 16'd7;
      @(negedge clk);
      tbw1 = 1'b0;
      start1 = 1'b1;
      w0 = cyc;
      lat = -1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (done1) begin
            lat = cyc - w0;
            break;
         end
      end
      check("small_latency", lat, 6);
      @(negedge clk);
      check("small_out", 32'($signed(ram1[2])), rx(-21));
      check("small_busy_idle", 32'(busy1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
